// File: rtl/dircc_send_handler.sv
// dircc_send_handler: builds one packet per send_request from the current
// device state, hands it out over a valid/ready port, then writes back the
// device state with its sent counter advanced.
// Optional feature: define DIRCC_SEND_TIMESTAMP_EN to stamp packets with a
// free-running 16-bit cycle counter; otherwise the tick field is zero.

package dircc_send_pkg;

    // Device state record: user_state[31:0] is the sent counter and
    // user_state[32] marks the device as a sender.
    typedef struct packed {
        logic [31:0] dircc_state;
        logic [31:0] dircc_state_extra;
        logic [63:0] user_state;
    } device_state_t;

    // Packet layout: [63] designated, [62:56] device, [55:48] address,
    // [47:32] tick, [31:0] id.
    typedef logic [63:0] packet_data_t;

endpackage

module dircc_send_handler
    import dircc_send_pkg::*;
#(
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int DEVICE_ID         = 0,
    parameter int MAX_PACKETS       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRESS_MEM_WIDTH-1:0] address,
    input  logic                         send_request,
    input  device_state_t                read_state,
    output packet_data_t                 packet_out,
    output logic                         packet_out_valid,
    input  logic                         packet_out_ready,
    output logic                         send_done,
    output logic                         rts,
    output device_state_t                write_state,
    output logic                         write_state_valid
);

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        SEND,
        UPDATE,
        DONE
    } state_t;

    localparam logic [31:0] MAX_COUNT = 32'(MAX_PACKETS);
    localparam logic [6:0]  DEV_FIELD = 7'(DEVICE_ID);

    state_t        state_q;
    packet_data_t  packet_q;
    packet_data_t  packet_d;
    logic          valid_q;
    logic          done_q;
    logic          ws_valid_q;
    device_state_t ws_q;
    device_state_t ws_d;
    device_state_t shadow_q;
    logic [15:0]   tick_now;

`ifdef DIRCC_SEND_TIMESTAMP_EN
    logic [15:0] tick_q;

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 16'd1;
        end
    end

    assign tick_now = tick_q;
`else
    assign tick_now = '0;
`endif

    // Only the low address byte fits in the packet; the rest is dropped.
    generate
        if (ADDRESS_MEM_WIDTH > 8) begin : g_addr_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^address[ADDRESS_MEM_WIDTH-1:8];
        end
    endgenerate

    // The device may send while it is a sender and below its packet quota.
    assign rts = read_state.user_state[32] && (read_state.user_state[31:0] < MAX_COUNT);

    // Packet assembled from the live state; captured into packet_q in BUILD.
    always_comb begin
        packet_d = {1'b1, DEV_FIELD, address[7:0], tick_now, read_state.user_state[31:0]};
    end

    // Write-back state: the shadow copy with the sent counter advanced.
    always_comb begin
        ws_d = shadow_q;
        ws_d.user_state[31:0] = shadow_q.user_state[31:0] + 32'd1;
    end

    // Transaction sequencer with registered handshake, strobe and data outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            packet_q   <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ws_valid_q <= 1'b0;
            ws_q       <= '0;
            shadow_q   <= '0;
        end else begin
            done_q     <= 1'b0;
            ws_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (send_request) begin
                        state_q <= BUILD;
                    end
                end
                BUILD: begin
                    packet_q <= packet_d;
                    shadow_q <= read_state;
                    if (rts) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (valid_q && packet_out_ready) begin
                        valid_q    <= 1'b0;
                        ws_q       <= ws_d;
                        ws_valid_q <= 1'b1;
                        state_q    <= UPDATE;
                    end
                end
                UPDATE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign packet_out        = packet_q;
    assign packet_out_valid  = valid_q;
    assign send_done         = done_q;
    assign write_state       = ws_q;
    assign write_state_valid = ws_valid_q;

endmodule
